// File: rtl/pool_quant_reader.sv
// Sweeps every PE bank / psum address and returns ReLU + shift-requantised, saturated rows.
// Optional 2:1 max-pool across adjacent addresses when POOL_MAXPOOL_EN is defined.
module pool_quant_reader #(
    parameter int unsigned NUMPEB     = 16,
    parameter int unsigned LENPSUM    = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PSUM_WIDTH = 24
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [4:0]                       cfg_shift_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [NUMPEB-1:0]                POOLPEB_EnRd_o,
    output logic [$clog2(LENPSUM)-1:0]       POOLPEB_AddrRd_o,
    input  logic [PSUM_WIDTH*LENPSUM-1:0]    PELPOOL_Dat_i,
    output logic                             out_val_o,
    input  logic                             out_rdy_i,
    output logic [DATA_WIDTH*LENPSUM-1:0]    out_dat_o,
    output logic [$clog2(NUMPEB)-1:0]        out_peb_o,
    output logic [$clog2(LENPSUM)-1:0]       out_row_o
);

    localparam int unsigned AW = $clog2(LENPSUM);
    localparam int unsigned BW = $clog2(NUMPEB);
    localparam logic [PSUM_WIDTH-1:0] SatMax = PSUM_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);

    typedef enum logic [2:0] {StIdle, StRd, StCap, StOut, StFin} state_e;

    state_e                               state_q, state_d;
    logic [BW-1:0]                        bank_q, bank_d;
    logic [AW-1:0]                        addr_q, addr_d;
    logic [4:0]                           shift_q, shift_d;
    logic [LENPSUM-1:0][DATA_WIDTH-1:0]   out_q, out_d;
    logic [LENPSUM-1:0][DATA_WIDTH-1:0]   quant_lanes;
    logic                                 last_addr, last_bank;

    // Negative psums and shifts past the psum width both collapse to zero.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic [PSUM_WIDTH-1:0] psum,
                                                      input logic [4:0]            shift);
        logic [PSUM_WIDTH-1:0] shifted;
        shifted = psum >> shift;
        if (psum[PSUM_WIDTH-1] || (32'(shift) >= PSUM_WIDTH)) begin
            return '0;
        end
        if (shifted > SatMax) begin
            return '1;
        end
        return shifted[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        quant_lanes = '0;
        for (int unsigned i = 0; i < LENPSUM; i++) begin
            quant_lanes[i] = requant(PELPOOL_Dat_i[i*PSUM_WIDTH +: PSUM_WIDTH], shift_q);
        end
    end

`ifdef POOL_MAXPOOL_EN
    logic [LENPSUM-1:0][DATA_WIDTH-1:0] pool_lanes;

    // out_q already holds the even-address row, so it doubles as the pair-max operand.
    always_comb begin
        pool_lanes = '0;
        for (int unsigned i = 0; i < LENPSUM; i++) begin
            pool_lanes[i] = (out_q[i] > quant_lanes[i]) ? out_q[i] : quant_lanes[i];
        end
    end
`endif

    assign last_addr = (addr_q == AW'(LENPSUM - 1));
    assign last_bank = (bank_q == BW'(NUMPEB - 1));

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        out_d   = out_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    shift_d = cfg_shift_i;
                    bank_d  = '0;
                    addr_d  = '0;
                    state_d = StRd;
                end
            end
            StRd: state_d = StCap;
            StCap: begin
`ifdef POOL_MAXPOOL_EN
                if (!addr_q[0]) begin
                    out_d   = quant_lanes;
                    addr_d  = addr_q + AW'(1);
                    state_d = StRd;
                end else begin
                    out_d   = pool_lanes;
                    state_d = StOut;
                end
`else
                out_d   = quant_lanes;
                state_d = StOut;
`endif
            end
            StOut: begin
                if (out_rdy_i) begin
                    addr_d = addr_q + AW'(1);
                    if (last_addr) begin
                        bank_d = bank_q + BW'(1);
                    end
                    state_d = (last_addr && last_bank) ? StFin : StRd;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bank_q  <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        POOLPEB_EnRd_o = '0;
        if (state_q == StRd) begin
            POOLPEB_EnRd_o = NUMPEB'(1) << bank_q;
        end
    end

    assign POOLPEB_AddrRd_o = (state_q == StRd) ? addr_q : '0;
    assign busy_o           = (state_q != StIdle) && (state_q != StFin);
    assign done_o           = (state_q == StFin);
    assign out_val_o        = (state_q == StOut);
    assign out_dat_o        = out_q;
    assign out_peb_o        = bank_q;
`ifdef POOL_MAXPOOL_EN
    assign out_row_o        = {1'b0, addr_q[AW-1:1]};
`else
    assign out_row_o        = addr_q;
`endif

endmodule

// File: tb/tb_pool_quant_reader.sv
// Self-checking bench for pool_quant_reader: vector table, hand sequences and randomized
// sweeps against a row-level reference model. Honours POOL_MAXPOOL_EN.
module tb_pool_quant_reader;

    localparam int NUMPEB  = 16;
    localparam int LENPSUM = 16;
    localparam int DW      = 8;
    localparam int PW      = 24;
`ifdef POOL_MAXPOOL_EN
    localparam bit Pool = 1'b1;
`else
    localparam bit Pool = 1'b0;
`endif
    localparam int Rows   = Pool ? LENPSUM / 2 : LENPSUM;
    localparam int Period = Pool ? 5 : 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   cfg_shift = '0;
    logic         busy, done;
    logic [15:0]  en;
    logic [3:0]   addr;
    logic [383:0] dat_in = '0;
    logic         out_val;
    logic         out_rdy = 1'b0;
    logic [127:0] out_dat;
    logic [3:0]   out_peb, out_row;

    pool_quant_reader #(
        .NUMPEB(NUMPEB), .LENPSUM(LENPSUM), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .cfg_shift_i(cfg_shift),
        .busy_o(busy), .done_o(done), .POOLPEB_EnRd_o(en), .POOLPEB_AddrRd_o(addr),
        .PELPOOL_Dat_i(dat_in), .out_val_o(out_val), .out_rdy_i(out_rdy),
        .out_dat_o(out_dat), .out_peb_o(out_peb), .out_row_o(out_row)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] dat;
        int           peb;
        int           row;
    } exp_t;

    typedef struct {
        int shift;
        int psum[4];
        int q[4];
    } vec_t;

    int           mem[NUMPEB][LENPSUM][LENPSUM];
    exp_t         exp_q[$];
    vec_t         vecs[6];
    int           n_cmp = 0, n_bad = 0;
    int           cyc = 0, hs_count = 0, done_count = 0, reads = 0;
    int           last_hs = -1, last_peb = -1, last_row = -1;
    bit           check_rate = 1'b0;
    logic [127:0] first_dat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_q(input int p, input int sh);
        int v;
        if (p < 0 || sh >= PW) return 0;
        v = p / (1 << sh);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic build_model(input int sh);
        exp_t e;
        int   a, b;
        exp_q.delete();
        for (int pb = 0; pb < NUMPEB; pb++) begin
            for (int r = 0; r < Rows; r++) begin
                e.dat = '0;
                e.peb = pb;
                e.row = r;
                for (int l = 0; l < LENPSUM; l++) begin
                    if (Pool) begin
                        a = ref_q(mem[pb][2*r][l], sh);
                        b = ref_q(mem[pb][2*r+1][l], sh);
                        e.dat[l*DW +: DW] = 8'((a > b) ? a : b);
                    end else begin
                        e.dat[l*DW +: DW] = 8'(ref_q(mem[pb][r][l], sh));
                    end
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill_mem();
        int x;
        for (int pb = 0; pb < NUMPEB; pb++)
            for (int a = 0; a < LENPSUM; a++)
                for (int l = 0; l < LENPSUM; l++) begin
                    x = int'($urandom);
                    mem[pb][a][l] = x >>> (8 + $urandom_range(0, 20));
                end
    endtask

    // Psum responder plus protocol/scoreboard checks, evaluated on the falling edge.
    task automatic monitor();
        bit           pend = 1'b0, prev_val = 1'b0, prev_rdy = 1'b0;
        int           pb = 0, pa = 0, prev_peb = 0, prev_row = 0;
        logic [127:0] prev_dat = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pend = 1'b0;
                prev_val = 1'b0;
                dat_in = {12{$urandom}};
                continue;
            end
            if (pend) begin
                for (int l = 0; l < LENPSUM; l++) dat_in[l*PW +: PW] = PW'(mem[pb][pa][l]);
            end else begin
                dat_in = {12{$urandom}};
            end
            pend = 1'b0;
            if (en != '0) begin
                reads++;
                chk("en_onehot", 128'($onehot(en)), 1);
                chk("rd_while_outval", out_val, 0);
                for (int b = 0; b < NUMPEB; b++) if (en[b]) pb = b;
                pa = int'(addr);
                pend = 1'b1;
            end
            if (prev_val && !prev_rdy) begin
                chk("stall_val", out_val, 1);
                chk("stall_dat", out_dat, prev_dat);
                chk("stall_peb", out_peb, prev_peb);
                chk("stall_row", out_row, prev_row);
            end
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_row", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("row_dat", out_dat, e.dat);
                    chk("row_peb", out_peb, e.peb);
                    chk("row_idx", out_row, e.row);
                end
                if (check_rate && last_hs >= 0) chk("row_period", cyc - last_hs, Period);
                hs_count++;
                last_hs  = cyc;
                last_peb = int'(out_peb);
                last_row = int'(out_row);
            end
            if (done) begin
                done_count++;
                chk("done_latency", cyc - last_hs, 1);
                chk("done_busy", busy, 0);
                chk("done_rows_left", exp_q.size(), 0);
            end
            prev_val = out_val;
            prev_rdy = out_rdy;
            prev_dat = out_dat;
            prev_peb = int'(out_peb);
            prev_row = int'(out_row);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_en"}, en, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_val"}, out_val, 0);
        chk({tag, "_dat"}, out_dat, 0);
        chk({tag, "_peb"}, out_peb, 0);
        chk({tag, "_row"}, out_row, 0);
    endtask

    // mode 0: out_rdy high; mode 1: random out_rdy.
    task automatic run_sweep(input int sh, input int mode, input int stall_row,
                             input int restart_at, input int abort_row);
        int n = 0, stall_left = 0, d0;
        bit stalled = 0, resume_next = 0, resume_chk, seen = 0;
        build_model(sh);
        hs_count   = 0;
        last_hs    = -1;
        check_rate = (mode == 0) && (stall_row < 0);
        d0         = done_count;
        cfg_shift  = 5'(sh);
        out_rdy    = 1'b1;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        cfg_shift = 5'($urandom);
        chk("start_busy", busy, 1);
        chk("start_en", en, 16'h0001);
        chk("start_addr", addr, 0);
        tick();
        chk("cap_val", out_val, 0);
        tick();
        chk("first_val", out_val, 1);
        chk("first_peb", out_peb, 0);
        chk("first_row", out_row, 0);
        first_dat = out_dat;
        while (n < 6000) begin
            if (abort_row >= 0 && hs_count >= abort_row) break;
            start = (restart_at >= 0 && n == restart_at);
            if (start) cfg_shift = 5'(sh + 7);
            if (stall_row >= 0 && !stalled && hs_count == stall_row && out_val) begin
                stalled    = 1;
                stall_left = 10;
            end
            resume_chk = 0;
            if (stall_left > 0) begin
                out_rdy = 1'b0;
                stall_left--;
                if (stall_left == 0) resume_next = 1;
            end else begin
                out_rdy = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (resume_next) begin
                    resume_chk  = 1;
                    resume_next = 0;
                end
            end
            tick();
            n++;
            if (resume_chk) chk("resume_rd", |en, 1);
            if (done) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        if (abort_row >= 0) return;
        if (!seen) begin
            chk("done_timeout", 0, 1);
        end else begin
            tick();
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("done_once", done_count - d0, 1);
            chk("row_total", hs_count, Rows * NUMPEB);
            chk("last_peb", last_peb, NUMPEB - 1);
            chk("last_row", last_row, Rows - 1);
        end
        out_rdy = 1'b0;
    endtask

    initial begin
        int d0;
        vecs[0] = '{shift: 2,  psum: '{-5, 0, 300, 100000},           q: '{0, 0, 75, 255}};
        vecs[1] = '{shift: 24, psum: '{8388607, 8388607, 8388607, 8388607}, q: '{0, 0, 0, 0}};
        vecs[2] = '{shift: 0,  psum: '{255, 256, -1, 0},              q: '{255, 255, 0, 0}};
        vecs[3] = '{shift: 31, psum: '{8388607, 1, 4095, 65536},      q: '{0, 0, 0, 0}};
        vecs[4] = '{shift: 4,  psum: '{4080, 4096, -8388608, 17},     q: '{255, 255, 0, 1}};
        vecs[5] = '{shift: 8,  psum: '{65535, 65536, 8388607, 255},   q: '{255, 255, 255, 0}};

        fork
            monitor();
        join_none

        // Reset and idle.
        repeat (3) tick();
        chk_outputs_zero("rst");
        rst_n = 1'b1;
        repeat (20) tick();
        chk_outputs_zero("idle");
        chk("idle_reads", reads, 0);

        // Quantisation vectors in bank 0, address 0 (address 1 zeroed so pooling keeps it).
        for (int v = 0; v < 6; v++) begin
            fill_mem();
            for (int l = 0; l < 4; l++) begin
                mem[0][0][l] = vecs[v].psum[l];
                mem[0][1][l] = 0;
            end
            run_sweep(vecs[v].shift, 0, -1, -1, -1);
            for (int l = 0; l < 4; l++) chk($sformatf("vec%0d_lane%0d", v, l),
                                            first_dat[l*DW +: DW], vecs[v].q[l]);
        end

`ifdef POOL_MAXPOOL_EN
        fill_mem();
        mem[0][0][0] = 40;
        mem[0][1][0] = 90;
        run_sweep(0, 0, -1, -1, -1);
        chk("pool_lane0", first_dat[7:0], 90);
`endif

        for (int k = 0; k < 3; k++) begin
            fill_mem();
            run_sweep((k == 2) ? 27 : int'($urandom_range(0, 12)), 1, -1, -1, -1);
        end

        // Backpressure at row 5.
        fill_mem();
        run_sweep(3, 0, 5, -1, -1);

        // start pulsed mid-sweep must not disturb the sweep.
        fill_mem();
        run_sweep(5, 0, -1, 40, -1);

        // Reset at row 37, then a clean sweep.
        fill_mem();
        run_sweep(6, 1, -1, -1, 37);
        d0 = done_count;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        repeat (3) tick();
        chk("midrst_no_done", done_count, d0);
        rst_n = 1'b1;
        tick();
        fill_mem();
        run_sweep(2, 1, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
